// File: rtl/reg_bank_pkg.sv
// Shared defaults and helpers for the multi-port register bank.
package reg_bank_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREAD  = 2;
   localparam int DEPTH      = 2**DEF_ADDR_W;

   // Low bit index of port k inside a packed bus of w-bit fields.
   function automatic int port_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/reg_bank_rport.sv
// One registered read port with write-first bypass from both write ports.
module reg_bank_rport
   import reg_bank_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ZERO_REG = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  rd_en,
   input  logic [ADDR_W-1:0]                     rd_addr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
   input  logic [(2**ADDR_W)-1:0]                busy,
   input  logic                                  w0_en,
   input  logic [ADDR_W-1:0]                     waddr0,
   input  logic [DATA_W-1:0]                     wdata0,
   input  logic                                  w1_en,
   input  logic [ADDR_W-1:0]                     waddr1,
   input  logic [DATA_W-1:0]                     wdata1,
   input  logic                                  rsv_en,
   input  logic [ADDR_W-1:0]                     rsv_addr,
   output logic [DATA_W-1:0]                     rd_data,
   output logic                                  rd_busy
);

   logic [DATA_W-1:0] nxt_data;
   logic              nxt_busy;

   // Mirror the write/reserve ordering of the storage so the port sees post-edge state.
   always_comb begin
      nxt_data = regs[rd_addr];
      nxt_busy = busy[rd_addr];
      if (w0_en && (waddr0 == rd_addr)) begin
         nxt_data = wdata0;
         nxt_busy = 1'b0;
      end
      if (w1_en && (waddr1 == rd_addr)) begin
         nxt_data = wdata1;
         nxt_busy = 1'b0;
      end
      if (rsv_en && (rsv_addr == rd_addr))
         nxt_busy = 1'b1;
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         nxt_data = '0;
         nxt_busy = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
         rd_busy <= 1'b0;
      end else if (rd_en) begin
         rd_data <= nxt_data;
         rd_busy <= nxt_busy;
      end
   end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register file: two write ports, NREAD bypassed read ports, busy scoreboard.
module reg_bank_mp
   import reg_bank_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NREAD    = DEF_NREAD,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic [NREAD*ADDR_W-1:0]  rd_addr,
   output logic [NREAD*DATA_W-1:0]  rd_data,
   output logic [NREAD-1:0]         rd_busy,
   output logic                     rd_valid,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata1,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr
);

   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0][DATA_W-1:0] regs;
   logic [NREG-1:0]             busy;
   logic                        w0_ok;
   logic                        w1_ok;
   logic                        rsv_ok;

   // Register 0 swallows writes and reserves when it is hardwired to zero.
   assign w0_ok  = we0    && !((ZERO_REG != 0) && (waddr0   == '0));
   assign w1_ok  = we1    && !((ZERO_REG != 0) && (waddr1   == '0));
   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Later assignments win: port 1 over port 0, and a reserve over the busy clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
         busy <= '0;
      end else begin
         if (w0_ok) begin
            regs[waddr0] <= wdata0;
            busy[waddr0] <= 1'b0;
         end
         if (w1_ok) begin
            regs[waddr1] <= wdata1;
            busy[waddr1] <= 1'b0;
         end
         if (rsv_ok)
            busy[rsv_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_valid <= 1'b0;
      else
         rd_valid <= rd_en;
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rport
      reg_bank_rport #(
         .ADDR_W   (ADDR_W),
         .DATA_W   (DATA_W),
         .ZERO_REG (ZERO_REG)
      ) u_rport (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (rd_en),
         .rd_addr  (rd_addr[port_lo(k, ADDR_W) +: ADDR_W]),
         .regs     (regs),
         .busy     (busy),
         .w0_en    (w0_ok),
         .waddr0   (waddr0),
         .wdata0   (wdata0),
         .w1_en    (w1_ok),
         .waddr1   (waddr1),
         .wdata1   (wdata1),
         .rsv_en   (rsv_ok),
         .rsv_addr (rsv_addr),
         .rd_data  (rd_data[port_lo(k, DATA_W) +: DATA_W]),
         .rd_busy  (rd_busy[k])
      );
   end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp with four read ports.
module tb_reg_bank_mp;

   logic          clk;
   logic          rst;
   logic          rd_en;
   logic [19:0]   rd_addr;
   logic [127:0]  rd_data;
   logic [3:0]    rd_busy;
   logic          rd_valid;
   logic          we0;
   logic [4:0]    waddr0;
   logic [31:0]   wdata0;
   logic          we1;
   logic [4:0]    waddr1;
   logic [31:0]   wdata1;
   logic          rsv_en;
   logic [4:0]    rsv_addr;

   int checks = 0;
   int errors = 0;

   reg_bank_mp #(
      .ADDR_W   (5),
      .DATA_W   (32),
      .NREAD    (4),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .rd_valid (rd_valid),
      .we0      (we0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1      (we1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sets the read request, crosses one rising edge, then drops write/reserve strobes.
   task automatic applyStimulus(input logic ren, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] a3);
      rd_en   = ren;
      rd_addr = {a3, a2, a1, a0};
      @(posedge clk);
      #1;
      we0    = 1'b0;
      we1    = 1'b0;
      rsv_en = 1'b0;
      rd_en  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] port_data(input int k);
      return rd_data[k*32 +: 32];
   endfunction

   initial begin
      rst = 1'b1;
      rd_en = 1'b0; rd_addr = '0;
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", {31'b0, rd_valid}, 32'h0);
      checkOutput("reset_data0", port_data(0), 32'h0);
      checkOutput("reset_busy", {28'b0, rd_busy}, 32'h0);
      rst = 1'b0;

      // Write reg 5, read it back, then asynchronously reset mid-cycle.
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 5'd0);
      checkOutput("pre_rst_data", port_data(0), 32'hDEADBEEF);
      checkOutput("pre_rst_valid", {31'b0, rd_valid}, 32'h1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_data", port_data(0), 32'h0);
      checkOutput("async_rst_valid", {31'b0, rd_valid}, 32'h0);
      checkOutput("async_rst_busy", {28'b0, rd_busy}, 32'h0);
      #1 rst = 1'b0;
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 5'd0);
      checkOutput("post_rst_reg5", port_data(0), 32'h0);

      // A write pending across a reset edge is discarded.
      we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'hCAFEF00D;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      rst = 1'b1;
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 5'd0);
      checkOutput("rst_discard_data", port_data(0), 32'h0);
      checkOutput("rst_discard_busy", {31'b0, rd_busy[0]}, 32'h0);

      // Same-cycle bypass from write port 0.
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h12345678;
      applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
      checkOutput("bypass_data", port_data(0), 32'h12345678);
      checkOutput("bypass_valid", {31'b0, rd_valid}, 32'h1);

      // Both ports hitting one address: port 1 wins, stored and bypassed.
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11111111;
      we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22222222;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 5'd0);
      checkOutput("collision_stored", port_data(0), 32'h22222222);
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hAAAA0000;
      we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hBBBB0000;
      applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 5'd0);
      checkOutput("collision_bypass", port_data(1), 32'hBBBB0000);

      // Scoreboard: reserve, clear by write, and reserve+write together.
      rsv_en = 1'b1; rsv_addr = 5'd9;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
      checkOutput("rsv_busy", {31'b0, rd_busy[0]}, 32'h1);
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h000000A5;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
      checkOutput("clr_busy", {31'b0, rd_busy[0]}, 32'h0);
      checkOutput("clr_data", port_data(0), 32'h000000A5);
      we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h00000055;
      rsv_en = 1'b1; rsv_addr = 5'd10;
      applyStimulus(1'b1, 5'd10, 5'd0, 5'd0, 5'd0);
      checkOutput("rsv_wr_bypass_busy", {31'b0, rd_busy[0]}, 32'h1);
      checkOutput("rsv_wr_bypass_data", port_data(0), 32'h00000055);
      applyStimulus(1'b1, 5'd0, 5'd10, 5'd0, 5'd0);
      checkOutput("rsv_wr_stored_busy", {31'b0, rd_busy[1]}, 32'h1);
      checkOutput("rsv_wr_stored_data", port_data(1), 32'h00000055);

      // Register 0 ignores writes and reserves.
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_bypass_p0", port_data(0), 32'h0);
      checkOutput("zero_bypass_p1", port_data(1), 32'h0);
      checkOutput("zero_bypass_busy", {28'b0, rd_busy}, 32'h0);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
      checkOutput("zero_stored", port_data(0), 32'h0);
      checkOutput("zero_stored_busy", {31'b0, rd_busy[1]}, 32'h0);

      // Fill 1..31 with 3*address, then four-port read and hold.
      for (int a = 1; a < 32; a++) begin
         we0 = 1'b1; waddr0 = 5'(a); wdata0 = 32'(a * 3);
         applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      end
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd1, 5'd31);
      checkOutput("mp_port0", port_data(0), 32'd3);
      checkOutput("mp_port1", port_data(1), 32'd6);
      checkOutput("mp_port2", port_data(2), 32'd3);
      checkOutput("mp_port3", port_data(3), 32'd93);
      checkOutput("mp_busy", {28'b0, rd_busy}, 32'h0);
      checkOutput("mp_valid", {31'b0, rd_valid}, 32'h1);
      applyStimulus(1'b0, 5'd4, 5'd5, 5'd6, 5'd7);
      checkOutput("hold_port0", port_data(0), 32'd3);
      checkOutput("hold_port1", port_data(1), 32'd6);
      checkOutput("hold_port2", port_data(2), 32'd3);
      checkOutput("hold_port3", port_data(3), 32'd93);
      checkOutput("hold_valid", {31'b0, rd_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port register file; successor to the single-write, dual-read register bank in the MIPS datapath.
- Generalises data width, depth and read-port count.
- Adds a second write port, write-first bypass, hardwired zero register, per-register busy scoreboard and asynchronous reset.
- Sits between decode (read/reserve) and writeback (ALU and memory write ports).

Parameters:
ADDR_W, 5, register address width; depth = 2**ADDR_W
DATA_W, 32, register data width
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
rd_en  in  1  read strobe shared by all read ports
rd_addr  in  NREAD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NREAD*DATA_W  registered read data, packed as rd_addr
rd_busy  out  NREAD  registered busy flag of each addressed register
rd_valid  out  1  high one cycle after a cycle with rd_en=1
we0  in  1  write enable, port 0 (ALU writeback)
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (memory writeback)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
rsv_en  in  1  reserve strobe, marks destination busy
rsv_addr  in  ADDR_W  register to reserve

Behaviour:
- Reset (rst=1, asynchronous): all registers 0, all busy bits 0, rd_data 0, rd_busy 0, rd_valid 0. Reset asserted mid-operation discards in-flight writes and reserves of that cycle. First update occurs on the first rising clk edge after rst falls.
- Writes: on rising clk, port p writes if we_p=1. Both ports targeting the same address: port 1 value stored.
- Clearing busy: every write clears the target's busy bit.
- Reserve: rsv_en=1 sets busy[rsv_addr] at rising clk. Same-cycle write and reserve to the same address: data is stored and busy ends 1 (new producer wins).
- Zero register: if ZERO_REG=1, address 0 writes and reserves are ignored. Reads of address 0 return 0 with busy 0.
- Read latency is 1 cycle. With rd_en=1 at edge N, rd_data/rd_busy reflect state after edge N's writes (write-first bypass). A read of an address written in the same cycle returns the new data (port 1 priority applies) and busy as updated by that edge.
- Read hold: with rd_en=0, rd_data and rd_busy hold their previous values and rd_valid=0 on the next cycle.
- Read ports are independent; identical addresses on several ports are legal and return identical data.
- Address range: full 2**ADDR_W range, no wrap or out-of-range cases. Widths are exact, with no sign extension.
- No back-pressure: every request completes in one cycle.

Decomposition:
- Package reg_bank_pkg:
  - default ADDR_W/DATA_W/NREAD constants;
  - function for packed-port slicing;
  - localparam DEPTH = 2**ADDR_W.
- Sub-module reg_bank_rport: one read port (array mux + two-port bypass compare + zero-reg force + output register). Instantiated NREAD times via generate.
- The storage array, busy vector and write/reserve logic stay in reg_bank_mp.

Test Plan:
- Reset: write reg 5=0xDEADBEEF, pulse rst mid-cycle asynchronously, read reg 5 -> rd_data=0x0, rd_busy=0, rd_valid 0 during reset.
- Bypass: we0=1 waddr0=7 wdata0=0x12345678 with rd_en=1 rd_addr port0=7 same cycle -> next cycle rd_data port0=0x12345678, rd_valid=1.
- Write collision: we0 (addr 3, 0x11111111) and we1 (addr 3, 0x22222222) same cycle; read 3 next cycle -> 0x22222222.
- Scoreboard: rsv_en addr 9, then read 9 -> rd_busy=1. Write 9=0xA5 -> next read busy=0, data 0xA5. Same-cycle reserve+write on 10 -> busy=1, data stored.
- Zero register: we0 addr 0 data 0xFFFFFFFF plus rsv_en addr 0, read 0 on both ports -> data 0, busy 0.
- Hold and multi-port: NREAD=4, read addresses 1,2,1,31 after writing 1..31 with value=address×3. Verify 3,6,3,93. Then rd_en=0 with changed addresses -> outputs unchanged, rd_valid=0.
